// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads the combinational instruction
// memory and loads an IF/ID register under a valid/ready handshake.
module fetch_ctrl #(
  parameter logic [11:0] RESET_PC = 12'h000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [11:0]      imem_addr,
  input  logic [31:0]      imem_data,
  input  logic             redirect_valid,
  input  logic [11:0]      redirect_target,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [11:0]      id_pc,
  output logic [11:0]      id_pc4,
  output logic             halted,
  output logic [11:0]      fault_pc,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {RUN, FAULT} state_t;

  state_t           state, state_nxt;
  logic [11:0]      pc, pc_nxt;
  logic             id_valid_nxt;
  logic [31:0]      id_instr_nxt;
  logic [11:0]      id_pc_nxt, id_pc4_nxt, fault_pc_nxt;
  logic [CNT_W-1:0] fetch_count_nxt;
  logic             fire;

  // A stalled IF/ID entry is only replaced once decode takes it.
  assign fire      = !id_valid || id_ready;
  assign imem_addr = pc;
  assign halted    = (state == FAULT);

  always_comb begin
    // NOTE: every next-value gets a hold default first, so no path can infer a latch.
    state_nxt       = state;
    pc_nxt          = pc;
    id_valid_nxt    = id_valid;
    id_instr_nxt    = id_instr;
    id_pc_nxt       = id_pc;
    id_pc4_nxt      = id_pc4;
    fault_pc_nxt    = fault_pc;
    fetch_count_nxt = fetch_count;

    case (state)
      RUN: begin
        if (redirect_valid) begin
          // A redirect kills IF/ID even while decode is stalling.
          id_valid_nxt = 1'b0;
          if (redirect_target[1:0] == 2'b00) begin
            pc_nxt = redirect_target;
          end else begin
            state_nxt    = FAULT;
            fault_pc_nxt = redirect_target;
          end
        end else if (fire) begin
          id_instr_nxt    = imem_data;
          id_pc_nxt       = pc;
          id_pc4_nxt      = pc + 12'd4;
          id_valid_nxt    = 1'b1;
          pc_nxt          = pc + 12'd4;
          fetch_count_nxt = fetch_count + CNT_W'(1);
        end
      end
      FAULT: begin
        // Sticky until reset; redirects are ignored.
      end
      default: state_nxt = FAULT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc4      <= '0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      id_valid    <= id_valid_nxt;
      id_instr    <= id_instr_nxt;
      id_pc       <= id_pc_nxt;
      id_pc4      <= id_pc4_nxt;
      fault_pc    <= fault_pc_nxt;
      fetch_count <= fetch_count_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed plan steps plus randomized
// stall/redirect traffic compared against a behavioural fetch model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [11:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [11:0] id_pc, id_pc4, fault_pc;
  logic        halted;
  logic [15:0] fetch_count;

  // Second instance with a reset PC at the top of memory.
  logic [11:0] d2_imem_addr;
  logic [31:0] d2_imem_data;
  logic        d2_id_valid, d2_halted;
  logic [31:0] d2_id_instr;
  logic [11:0] d2_id_pc, d2_id_pc4, d2_fault_pc;
  logic [15:0] d2_fetch_count;

  logic [7:0] mem [4096];

  int tests = 0;
  int fails = 0;

  // Behavioural model of the architecturally visible fetch state.
  logic [11:0] m_pc;
  logic        m_valid, m_halted;
  logic [31:0] m_instr;
  logic [11:0] m_id_pc, m_id_pc4, m_fault;
  int          m_count;

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [11:0] a);
    return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
  endfunction

  assign imem_data    = rd(imem_addr);
  assign d2_imem_data = rd(d2_imem_addr);

  fetch_ctrl #(.RESET_PC(12'h000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc4(id_pc4), .halted(halted), .fault_pc(fault_pc),
    .fetch_count(fetch_count)
  );

  fetch_ctrl #(.RESET_PC(12'hFFC), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .imem_addr(d2_imem_addr), .imem_data(d2_imem_data),
    .redirect_valid(1'b0), .redirect_target(12'h000),
    .id_ready(1'b1), .id_valid(d2_id_valid), .id_instr(d2_id_instr),
    .id_pc(d2_id_pc), .id_pc4(d2_id_pc4), .halted(d2_halted), .fault_pc(d2_fault_pc),
    .fetch_count(d2_fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 12'h000; m_valid = 1'b0; m_halted = 1'b0; m_instr = '0;
    m_id_pc = '0; m_id_pc4 = '0; m_fault = '0; m_count = 0;
  endtask

  // Apply the fetch rules to the model for the inputs currently driven.
  task automatic model_step();
    if (m_halted) return;
    if (redirect_valid) begin
      m_valid = 1'b0;
      if (redirect_target % 4 == 0) m_pc = redirect_target;
      else begin m_halted = 1'b1; m_fault = redirect_target; end
    end else if (!m_valid || id_ready) begin
      m_instr  = rd(m_pc);
      m_id_pc  = m_pc;
      m_id_pc4 = 12'((m_pc + 4) % 4096);
      m_pc     = 12'((m_pc + 4) % 4096);
      m_valid  = 1'b1;
      m_count  = (m_count + 1) % 65536;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".imem_addr"},   imem_addr,   m_pc);
    check({tag, ".id_valid"},    id_valid,    m_valid);
    check({tag, ".id_instr"},    id_instr,    m_instr);
    check({tag, ".id_pc"},       id_pc,       m_id_pc);
    check({tag, ".id_pc4"},      id_pc4,      m_id_pc4);
    check({tag, ".halted"},      halted,      m_halted);
    check({tag, ".fault_pc"},    fault_pc,    m_fault);
    check({tag, ".fetch_count"}, fetch_count, 32'(m_count));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0; id_ready = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'd19; mem[1] = 8'd6; mem[2] = 8'd80; mem[3] = 8'd0;
    mem[4] = 8'd99; mem[5] = 8'd4; mem[6] = 8'd6; mem[7] = 8'd6;
    mem[52] = 8'd227; mem[53] = 8'd10; mem[54] = 8'd198; mem[55] = 8'd254;
    model_reset();

    #2;
    compare_all("reset");
    check("reset.d2_imem_addr", d2_imem_addr, 12'hFFC);
    reset = 1'b0;

    // Plan 1: back-to-back fetch from address 0.
    check("t1.addr0", imem_addr, 12'h000);
    tick("t1.e1");
    check("t1.e1.instr", id_instr, 32'h00500613);
    check("t1.e1.pc4", id_pc4, 12'h004);
    check("t5.d2_id_pc", d2_id_pc, 12'hFFC);
    check("t5.d2_id_pc4", d2_id_pc4, 12'h000);
    check("t5.d2_imem_addr", d2_imem_addr, 12'h000);
    check("t5.d2_id_instr", d2_id_instr, rd(12'hFFC));
    tick("t1.e2");
    check("t1.e2.instr", id_instr, 32'h06060463);
    check("t1.e2.addr", imem_addr, 12'h008);
    check("t1.e2.count", fetch_count, 16'd2);

    // Plan 2: three-cycle stall holds everything.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick("t2.stall");
    check("t2.instr", id_instr, 32'h06060463);
    check("t2.id_pc", id_pc, 12'h004);
    check("t2.count", fetch_count, 16'd2);
    id_ready = 1'b1;
    tick("t2.resume");
    check("t2.resume.id_pc", id_pc, 12'h008);

    // Plan 3: redirect overrides stall.
    redirect_valid = 1'b1; redirect_target = 12'h034; id_ready = 1'b0;
    tick("t3.redir");
    check("t3.redir.valid", id_valid, 1'b0);
    check("t3.redir.addr", imem_addr, 12'h034);
    redirect_valid = 1'b0;
    tick("t3.fetch");
    check("t3.instr", id_instr, 32'hFEC60AE3);
    check("t3.id_pc4", id_pc4, 12'h038);

    // Randomized stalls and aligned redirects.
    for (int i = 0; i < 400; i++) begin
      id_ready        = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 15) == 0);
      redirect_target = {10'($urandom), 2'b00};
      tick("rand");
    end

    // Plan 4: misaligned redirect faults and stays halted.
    redirect_valid = 1'b1; redirect_target = 12'h036;
    tick("t4.fault");
    check("t4.halted", halted, 1'b1);
    check("t4.fault_pc", fault_pc, 12'h036);
    redirect_target = 12'h000; id_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick("t4.sticky");
    redirect_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t4.reset.halted", halted, 1'b0);
    model_reset();
    compare_all("t4.reset");

    // Plan 6: async reset in the middle of a stall.
    #3 reset = 1'b0;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick("t6.run");
    id_ready = 1'b0;
    tick("t6.stall");
    check("t6.stall.valid", id_valid, 1'b1);
    #3 reset = 1'b1;
    #1;
    check("t6.valid", id_valid, 1'b0);
    check("t6.addr", imem_addr, 12'h000);
    check("t6.count", fetch_count, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences instruction fetch for the 4 KiB byte-addressed instruction memory.
- Owns the 12-bit program counter and drives it to the memory's combinational read port.
- Captures the returned little-endian 32-bit word into an IF/ID register with a valid/ready handshake.
- Handles pipeline stalls, branch/jump redirects, misaligned-target faults and a retired-fetch counter.
- Sits between instruction memory / PC+4 logic and the decode stage.

Parameters:
RESET_PC, 12'h000, PC value loaded on reset.
CNT_W, 16, width of fetch_count.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
imem_addr  out  12  byte address to instruction memory; always equals current PC register.
imem_data  in  32  instruction word returned combinationally for imem_addr.
redirect_valid  in  1  branch/jump taken; replace PC and kill IF/ID contents.
redirect_target  in  12  new byte PC; sampled when redirect_valid=1.
id_ready  in  1  decode stage can accept IF/ID contents this cycle.
id_valid  out  1  IF/ID register holds a valid instruction.
id_instr  out  32  fetched instruction word.
id_pc  out  12  PC of id_instr.
id_pc4  out  12  id_pc + 4, modulo 2^12.
halted  out  1  controller is in FAULT.
fault_pc  out  12  offending redirect target latched on fault entry.
fetch_count  out  CNT_W  number of fetches loaded into IF/ID.

Behaviour:
Clock, reset and memory interface
- Single clock domain; reset is asynchronous and active-high.
- Reset values take effect immediately, without a clock edge: pc=RESET_PC, state=RUN, id_valid=0, id_instr=0, id_pc=0, id_pc4=0, halted=0, fault_pc=0, fetch_count=0.
- imem_addr = pc (registered source, no combinational input paths). imem_data is valid in the same cycle; fetch latency is 1 clock from PC to IF/ID.

State RUN, evaluated in this priority order each rising edge:
1. redirect_valid=1, redirect_target[1:0]==0:
   - pc<=redirect_target; id_valid<=0; no fetch this cycle.
   - Overrides any stall, so the killed instruction is dropped even if id_ready=0.
2. redirect_valid=1, redirect_target[1:0]!=0:
   - state<=FAULT; halted<=1; fault_pc<=redirect_target; id_valid<=0; pc unchanged.
3. Fire condition (!id_valid || id_ready):
   - id_instr<=imem_data; id_pc<=pc; id_pc4<=pc+4; id_valid<=1.
   - pc<=pc+4, wrapping 12'hFFC->12'h000 silently.
   - fetch_count<=fetch_count+1, wrapping at 2^CNT_W.
4. Otherwise (stall: id_valid && !id_ready): hold pc, all IF/ID registers and fetch_count.

Handshake
- A transfer to decode occurs on a cycle with id_valid && id_ready.
- When the IF/ID register is valid and not being accepted, its contents must not change, except when killed by a redirect.
- Back-to-back fetch with id_ready held at 1 gives one instruction per cycle.

State FAULT (sticky until reset)
- No fetch; pc, fetch_count and fault_pc hold; redirect_valid is ignored.
- id_valid is already 0 on entry, so decode receives nothing further. id_ready is don't-care.

Reset mid-operation
- Any in-flight IF/ID contents are discarded.
- First fetch after reset deassertion happens on the first rising edge: id_pc=RESET_PC.

Test Plan:
1. Memory bytes 0..7 = 19,6,80,0,99,4,6,6; RESET_PC=0; id_ready=1; release reset -> edge 1: id_valid=1, id_instr=0x00500613, id_pc=0, id_pc4=4; edge 2: id_instr=0x06060463, id_pc=4; imem_addr sequence 0,4,8; fetch_count=2.
2. After test 1, hold id_ready=0 for 3 cycles -> id_instr=0x06060463, id_pc=4, imem_addr=8 and fetch_count=2 held; id_ready=1 -> next edge id_pc=8.
3. Bytes 52..55 = 227,10,198,254; redirect_valid=1, target=12'h034, id_ready=0 -> next edge id_valid=0, imem_addr=0x034; following edge id_instr=0xFEC60AE3, id_pc=0x034, id_pc4=0x038.
4. Redirect target=12'h036 -> halted=1, fault_pc=0x036, id_valid=0; 5 further cycles with id_ready=1 and redirect to 0x000 -> no change; assert reset -> halted=0 immediately.
5. RESET_PC=12'hFFC -> first fetch id_pc=0xFFC, id_pc4=0x000; imem_addr then 0x000.
6. Assert reset asynchronously mid-stall, between clock edges -> id_valid=0, imem_addr=RESET_PC and fetch_count=0 before the next rising edge.
